instr_sequencer: RTL and testbench

Multi-cycle control unit for the 16-bit processor datapath. It fetches 16-bit instructions over a req/ack port, decodes opcode and register fields, and drives the datapath's control inputs: op_code, rs/rt/rd offsets, shamt, constant and sel. Each instruction is issued as a one-cycle strobe. Multiply results get a programmable settle window before the next fetch.

---
 rtl/instr_sequencer_if.sv | 24 ++
 rtl/instr_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Instruction fetch port of instr_sequencer: the master holds req/addr
// until the slave answers with ack and rdata in the same cycle.
interface instr_sequencer_if #(
    parameter int AW = 8
);
    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [15:0]   rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/issue sequencer for the 16-bit datapath.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes set err and halt.
module instr_sequencer #(
    parameter int AW      = 8,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    instr_sequencer_if.master imem,
    output logic              dp_valid,
    output logic [3:0]        dp_op_code,
    output logic [2:0]        dp_rs,
    output logic [2:0]        dp_rt,
    output logic [2:0]        dp_rd,
    output logic [2:0]        dp_shamt,
    output logic [5:0]        dp_constant,
    output logic              dp_sel,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [15:0]       retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MULW,
        S_HALT
    } state_e;

    localparam logic [3:0] OP_HALT = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1110;
    localparam logic [3:0] MUL_WAIT = 4'(MUL_LAT - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [3:0]    op_q, op_d;
    logic [2:0]    rs_q, rs_d;
    logic [2:0]    rt_q, rt_d;
    logic [2:0]    rd_q, rd_d;
    logic [2:0]    sh_q, sh_d;
    logic [5:0]    k_q, k_d;
    logic          sel_q, sel_d;
    logic          err_q, err_d;
    logic [15:0]   ret_q, ret_d;
    logic [3:0]    cnt_q, cnt_d;

    logic [3:0]    ir_op;
    logic          op_halt;
    logic          op_ill;
    logic          op_imm;
    logic [AW-1:0] pc_inc;

    assign ir_op   = ir_q[15:12];
    assign op_halt = (ir_op == OP_HALT);
    assign op_ill  = (ir_op == 4'b1010)
                  || (ir_op == 4'b1011)
                  || (ir_op == 4'b1100);
    assign op_imm  = (ir_op >= 4'b0101)
                  && (ir_op <= 4'b1000);
    assign pc_inc  = pc_q + AW'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        sh_d    = sh_q;
        k_d     = k_q;
        sel_d   = sel_q;
        err_d   = err_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    err_d   = 1'b0;
                    ret_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem.ack) begin
                    ir_d    = imem.rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    op_halt: state_d = S_HALT;
                    op_ill: begin
`ifdef ILLEGAL_TRAP_EN
                        err_d   = 1'b1;
                        state_d = S_HALT;
`else
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
`endif
                    end
                    default: begin
                        op_d = ir_op;
                        rs_d = ir_q[11:9];
                        rt_d = ir_q[8:6];
                        if (op_imm) begin
                            rd_d  = '0;
                            sh_d  = '0;
                            k_d   = ir_q[5:0];
                            sel_d = 1'b1;
                        end else begin
                            rd_d  = ir_q[5:3];
                            sh_d  = ir_q[2:0];
                            k_d   = '0;
                            sel_d = 1'b0;
                        end
                        state_d = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                if (ret_q != 16'hFFFF) begin
                    ret_d = ret_q + 16'd1;
                end
                if (op_q == OP_MUL) begin
                    cnt_d   = MUL_WAIT;
                    state_d = S_MULW;
                end else begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_MULW: begin
                if (cnt_q == 4'd0) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            sh_q    <= '0;
            k_q     <= '0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
            ret_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            sh_q    <= sh_d;
            k_q     <= k_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    // addr comes straight from PC, so it cannot move while req is held
    assign imem.req    = (state_q == S_FETCH);
    assign imem.addr   = pc_q;

    assign dp_valid    = (state_q == S_EXEC);
    assign dp_op_code  = op_q;
    assign dp_rs       = rs_q;
    assign dp_rt       = rt_q;
    assign dp_rd       = rd_q;
    assign dp_shamt    = sh_q;
    assign dp_constant = k_q;
    assign dp_sel      = sel_q;

    assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted  = (state_q == S_HALT);
    assign err     = err_q;
    assign retired = ret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: vector table, random programs against a
// program-level model, and hand sequences for wrap and reset corners.
`timescale 1ns/1ps
module tb_instr_sequencer;

    localparam int AW = 8;
    localparam int ML = 3;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start;
    logic        dp_valid, dp_sel, busy, halted, err;
    logic [3:0]  dp_op_code;
    logic [2:0]  dp_rs, dp_rt, dp_rd, dp_shamt;
    logic [5:0]  dp_constant;
    logic [15:0] retired;

    logic        rst2_n, start2;
    logic        v2, sel2, busy2, halted2, err2;
    logic [3:0]  op2;
    logic [2:0]  rs2, rt2, rd2, sh2;
    logic [5:0]  k2;
    logic [15:0] ret2;

    instr_sequencer_if #(.AW(AW)) bus ();
    instr_sequencer_if #(.AW(2))  bus2 ();

    instr_sequencer #(.AW(AW), .MUL_LAT(ML)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem(bus),
        .dp_valid(dp_valid), .dp_op_code(dp_op_code),
        .dp_rs(dp_rs), .dp_rt(dp_rt), .dp_rd(dp_rd),
        .dp_shamt(dp_shamt), .dp_constant(dp_constant),
        .dp_sel(dp_sel), .busy(busy), .halted(halted),
        .err(err), .retired(retired)
    );

    instr_sequencer #(.AW(2), .MUL_LAT(ML)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .start(start2), .imem(bus2),
        .dp_valid(v2), .dp_op_code(op2),
        .dp_rs(rs2), .dp_rt(rt2), .dp_rd(rd2),
        .dp_shamt(sh2), .dp_constant(k2),
        .dp_sel(sel2), .busy(busy2), .halted(halted2),
        .err(err2), .retired(ret2)
    );

    typedef struct {
        logic [22:0] f;
        int          cyc;
    } iss_t;

    typedef struct {
        logic [15:0] w;
        logic [22:0] f;
        int          halt_cyc;
        int          gap;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0    = 0;
    int mem_wait = 0;
    int exp_halt;
    bit exp_err;
    bit hold2 = 1'b0;

    logic [15:0] mem  [256];
    logic [15:0] mem2 [4];
    iss_t obs_q[$];
    iss_t exp_q[$];
    int   rise_q[$];
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [22:0] mk(input int op, input int rs,
        input int rt, input int rd, input int sh, input int k,
        input int sel);
        return {4'(op), 3'(rs), 3'(rt), 3'(rd), 3'(sh), 6'(k), 1'(sel)};
    endfunction

    // Field split straight from the instruction format rules
    function automatic logic [22:0] fld(input logic [15:0] w);
        int v, op;
        bit imm;
        v   = int'(w);
        op  = (v >> 12) & 15;
        imm = (op >= 5 && op <= 8);
        return mk(op, (v >> 9) & 7, (v >> 6) & 7,
                  imm ? 0 : (v >> 3) & 7, imm ? 0 : v & 7,
                  imm ? v & 63 : 0, imm ? 1 : 0);
    endfunction

    // Interprets the program in mem and predicts issues and cycle times
    function automatic void model_run(input int wt);
        int pc, t, dec, op;
        iss_t e;
        exp_q.delete();
        exp_halt = -1;
        exp_err  = 1'b0;
        pc = 0;
        t  = 1;
        for (int n = 0; n < 300; n++) begin
            op  = int'(mem[pc]) >> 12;
            dec = t + wt + 1;
            if (op == 9) begin
                exp_halt = dec + 1;
                break;
            end
            if (op >= 10 && op <= 12) begin
                if (TRAP) begin
                    exp_err  = 1'b1;
                    exp_halt = dec + 1;
                    break;
                end
                pc = (pc + 1) % 256;
                t  = dec + 1;
                continue;
            end
            e.f   = fld(mem[pc]);
            e.cyc = dec + 1;
            exp_q.push_back(e);
            pc = (pc + 1) % 256;
            t  = dec + 2 + ((op == 14) ? ML : 0);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin : mon
        bit req_prev;
        iss_t e;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (dp_valid) begin
                e.f = {dp_op_code, dp_rs, dp_rt, dp_rd, dp_shamt,
                       dp_constant, dp_sel};
                e.cyc = cyc - c0;
                obs_q.push_back(e);
            end
            if (bus.req && !req_prev) rise_q.push_back(cyc - c0);
            req_prev = bus.req;
        end
    end

    // Memory with programmable wait, ack noise while idle, hold checks
    initial begin : resp
        int wcnt;
        bit hold;
        logic [AW-1:0] haddr;
        bus.ack = 1'b0;
        bus.rdata = '0;
        wcnt = 0;
        hold = 1'b0;
        haddr = '0;
        forever begin
            @(negedge clk);
            if (hold && rst_n)
                chk("req_hold", 32'({bus.req, bus.addr}),
                    32'({1'b1, haddr}));
            if (bus.req) begin
                haddr = bus.addr;
                if (wcnt >= mem_wait) begin
                    bus.ack = 1'b1;
                    bus.rdata = mem[bus.addr];
                    wcnt = 0;
                end else begin
                    bus.ack = 1'b0;
                    bus.rdata = 16'($urandom);
                    wcnt++;
                end
            end else begin
                bus.ack = 1'($urandom);
                bus.rdata = 16'($urandom);
                wcnt = 0;
            end
            hold = bus.req && !bus.ack;
            if (!rst_n) begin
                hold = 1'b0;
                wcnt = 0;
            end
        end
    end

    initial begin
        bus2.ack = 1'b0;
        bus2.rdata = '0;
        forever begin
            @(negedge clk);
            bus2.ack = bus2.req && !hold2;
            bus2.rdata = mem2[bus2.addr];
        end
    end

    task automatic chk_reset(input string nm);
        chk({nm, "_dp"}, 32'({dp_valid, dp_op_code, dp_rs, dp_rt,
            dp_rd, dp_shamt, dp_constant, dp_sel}), 32'd0);
        chk({nm, "_st"}, 32'({bus.req, bus.addr, busy, halted, err}),
            32'd0);
        chk({nm, "_ret"}, 32'(retired), 32'd0);
    endtask

    task automatic run(input int wt, input bit poke, output int got);
        mem_wait = wt;
        @(posedge clk);
        #1;
        obs_q.delete();
        rise_q.delete();
        c0 = cyc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (poke) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        got = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (halted) begin
                got = cyc - c0;
                break;
            end
        end
    endtask

    task automatic check_run(input string nm, input int got,
                             input int eh, input int er, input bit ee);
        chk({nm, "_nissue"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({nm, "_fields"}, 32'(obs_q[i].f), 32'(exp_q[i].f));
            chk({nm, "_iss_cyc"}, obs_q[i].cyc, exp_q[i].cyc);
        end
        chk({nm, "_halt_cyc"}, got, eh);
        chk({nm, "_retired"}, 32'(retired), er);
        chk({nm, "_err"}, 32'(err), 32'(ee));
        chk({nm, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int got;
        int nr;
        bit prev, seen;
        iss_t e;

        tbl[0] = '{16'h0288, mk(0, 1, 2, 1, 0, 0, 0), 6, 1};
        tbl[1] = '{16'h6A3F, mk(6, 5, 0, 0, 0, 63, 1), 6, 1};
        tbl[2] = '{16'hE1D3, mk(14, 0, 7, 2, 3, 0, 0), 6 + ML, ML + 1};
        tbl[3] = '{16'h8FC5, mk(8, 7, 7, 0, 0, 5, 1), 6, 1};
        tbl[4] = '{16'h4B6E, mk(4, 5, 5, 5, 6, 0, 0), 6, 1};
        tbl[5] = '{16'hD0FF, mk(13, 0, 3, 7, 7, 0, 0), 6, 1};
        tbl[6] = '{16'h5040, mk(5, 0, 1, 0, 0, 0, 1), 6, 1};
        tbl[7] = '{16'hF249, mk(15, 1, 1, 1, 1, 0, 0), 6, 1};

        for (int i = 0; i < 256; i++) mem[i] = 16'h9000;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        rst_n = 1'b1;
        rst2_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            mem[0] = tbl[i].w;
            mem[1] = 16'h9000;
            exp_q.delete();
            e.f = tbl[i].f;
            e.cyc = 3;
            exp_q.push_back(e);
            run(0, 1'b0, got);
            check_run("tbl", got, tbl[i].halt_cyc, 1, 1'b0);
            chk("tbl_gap", (rise_q.size() >= 2 && obs_q.size() >= 1)
                ? rise_q[1] - obs_q[0].cyc : -1, tbl[i].gap);
        end

        mem[0] = 16'h0288;
        mem[1] = 16'h6A3F;
        mem[2] = 16'h9000;
        model_run(4);
        run(4, 1'b0, got);
        check_run("wait4", got, exp_halt, exp_q.size(), exp_err);
        chk("wait4_n", obs_q.size(), 2);

        mem[0] = 16'hB000;
        mem[1] = 16'h0288;
        mem[2] = 16'h9000;
        model_run(0);
        run(0, 1'b0, got);
        check_run("ill", got, exp_halt, exp_q.size(), exp_err);
        chk("ill_err", 32'(err), TRAP ? 32'd1 : 32'd0);
        chk("ill_n", obs_q.size(), TRAP ? 0 : 1);
        chk("ill_halt", got, TRAP ? 3 : 8);

        for (int r = 0; r < 30; r++) begin
            int len, wt;
            logic [15:0] w;
            len = $urandom_range(1, 10);
            for (int j = 0; j < len; j++) begin
                w = 16'($urandom);
                if (w[15:12] == 4'h9) w[15:12] = 4'hE;
                mem[j] = w;
            end
            mem[len] = 16'h9000;
            wt = $urandom_range(0, 4);
            model_run(wt);
            run(wt, 1'($urandom), got);
            check_run("rand", got, exp_halt, exp_q.size(), exp_err);
        end

        mem2[0] = 16'h0288;
        mem2[1] = 16'h6A3F;
        mem2[2] = 16'h4B6E;
        mem2[3] = 16'hD0FF;
        @(posedge clk);
        #1;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        nr = 0;
        prev = 1'b0;
        for (int i = 0; i < 60 && nr < 5; i++) begin
            if (bus2.req && !prev) begin
                chk("wrap_addr", 32'(bus2.addr), 32'(nr % 4));
                nr++;
            end
            prev = bus2.req;
            if (nr < 5) begin
                @(posedge clk);
                #1;
            end
        end
        chk("wrap_rises", nr, 5);
        chk("wrap_ret", 32'(ret2), 32'd4);
        hold2 = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap_held", 32'({bus2.req, bus2.addr}), 32'd4);
        #2;
        rst2_n = 1'b0;
        #1;
        chk("rst2_ctl", 32'({bus2.req, bus2.addr, v2, op2, rs2, rt2,
            rd2, sh2, k2, sel2, busy2, halted2, err2}), 32'd0);
        chk("rst2_ret", 32'(ret2), 32'd0);
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        hold2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst2_idle", 32'({bus2.req, busy2, halted2, v2}), 32'd0);

        mem[0] = 16'hE000;
        mem[1] = 16'h9000;
        mem_wait = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("mulw_issue", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        chk("mulw_state", 32'({busy, halted, bus.req}), 32'b100);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mulw");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_reset("idle_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
